ft6206_poll_controller: RTL and testbench
=========================================

FT6206_POLL_CONTROLLER -- requirements
Module: ft6206_poll_controller

Interface
REQ-001 SHALL have parameter CLK_HZ, default 12_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter POLL_HZ, default 100, touch poll rate; POLL_CYCLES = CLK_HZ/POLL_HZ (120_000 by default).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 4096, maximum cycles from request acceptance to done or nack.
REQ-004 SHALL have parameter I2C_ADDR, default 7'h38, FT6206 7-bit device address.
REQ-005 SHALL have the following ports:
- clk  in  1  system clock.
- rst  in  1  reset; one clock, asynchronous, active-high.
- ena  in  1  polling enable.
- req_valid  out  1  register-read request to the I2C engine.
- req_ready  in  1  engine accepts the request.
- req_addr  out  7  device address; always I2C_ADDR.
- req_reg  out  8  start register.
- req_len  out  3  byte count.
- rd_valid  in  1  one read byte is presented.
- rd_data  in  8  read byte.
- done  in  1  one-cycle pulse: transaction completed.
- nack  in  1  one-cycle pulse: transaction aborted.
- touch_valid  out  1  one-cycle pulse: new sample.
- touch_active  out  1  at least one touch present.
- touch_x  out  9  clamped X coordinate, 0..239.
- touch_y  out  9  clamped Y coordinate, 0..319.
- err_count  out  8  saturating error count.
- busy  out  1  high in every state except WAIT.

Function
REQ-006 SHALL implement the states WAIT, REQ, RECV, UPDATE and ERR.
REQ-007 In WAIT, SHALL decrement a poll timer each cycle while ena=1 and hold it while ena=0.
REQ-008 In WAIT, SHALL go to REQ on the cycle the timer is 0 and ena=1, reloading the timer to POLL_CYCLES-1.
REQ-009 In REQ, SHALL drive req_valid=1, req_reg=8'h02 and req_len=3'd5, all stable until req_ready=1.
REQ-010 SHALL treat the request as accepted on a cycle with req_valid and req_ready both 1, then enter RECV and clear the byte index and the timeout counter.
REQ-011 SHALL drive req_valid=0 in every state except REQ.
REQ-012 In RECV, SHALL store each rd_valid byte at the byte index, then increment the index.
- Byte order: TD_STATUS, P1_XH, P1_XL, P1_YH, P1_YL.
- Bytes beyond index 4 are ignored.
REQ-013 In RECV, a done pulse with exactly 5 bytes received SHALL go to UPDATE.
REQ-014 In RECV, done with fewer than 5 bytes, nack, or the timeout counter reaching TIMEOUT_CYCLES SHALL go to ERR.
REQ-015 If nack and done occur in the same cycle, nack SHALL take priority.
REQ-016 If done and a final rd_valid occur in the same cycle, that byte SHALL be counted before the 5-byte check.
REQ-017 UPDATE SHALL last one cycle, return to WAIT, and on that cycle:
- raw_x = {P1_XH[3:0], P1_XL}; raw_y = {P1_YH[3:0], P1_YL}; both 12 bits.
- touch_active <= (TD_STATUS[3:0] != 0) and (TD_STATUS[3:0] <= 2); values 3..15 are treated as no touch.
- If touch_active is true: touch_x <= min(raw_x, 239) and touch_y <= min(raw_y, 319).
- If touch_active is false: touch_x and touch_y hold their previous values.
- touch_valid = 1.
REQ-018 ERR SHALL last one cycle, increment err_count saturating at 255, leave the touch outputs unchanged, and return to WAIT.
REQ-019 The poll timer SHALL keep running in REQ and RECV, so poll start times do not drift; if it reaches 0 before the return to WAIT, it SHALL hold at 0 and a poll SHALL start on the first WAIT cycle.
REQ-020 Deasserting ena mid-transaction SHALL NOT abort the transaction; polling stops on return to WAIT.
REQ-021 touch_valid SHALL be high for exactly one cycle per UPDATE and never in any other state.
REQ-022 All outputs SHALL be registered except req_valid, req_addr, req_reg, req_len and busy, which are decoded from the state.

Reset
REQ-023 While rst=1, SHALL force state=WAIT, poll timer=POLL_CYCLES-1, byte index=0 and timeout counter=0.
REQ-024 While rst=1, SHALL force the outputs to: req_valid=0, touch_valid=0, touch_active=0, touch_x=0, touch_y=0, err_count=0, busy=0.
REQ-025 Reset asserted mid-transaction SHALL abandon it immediately, without waiting for done or nack.
REQ-026 After rst is released, the first req_valid SHALL occur exactly POLL_CYCLES cycles later, given ena=1.

Verification
REQ-027 Bench: POLL_HZ set so POLL_CYCLES=1000, ena=1, engine returns 01,00,64,01,2C then done -> touch_valid pulse with touch_active=1, touch_x=100, touch_y=300; next req_valid 1000 cycles after the previous one.
REQ-028 Bench: bytes 02,0F,FF,0F,FF -> touch_x=239, touch_y=319, touch_active=1; then bytes 00,xx,xx,xx,xx -> touch_active=0 with X/Y unchanged.
REQ-029 Bench: nack after 2 bytes -> no touch_valid, err_count=1; 300 consecutive nacks -> err_count holds at 255.
REQ-030 Bench: engine never asserts done -> ERR exactly TIMEOUT_CYCLES cycles after acceptance, err_count increments, polling resumes on schedule.
REQ-031 Bench: req_ready held low for 50 cycles -> req_valid, req_reg=02 and req_len=5 stable throughout; ena=0 at reset release -> no req_valid for 5000 cycles.
REQ-032 Bench: rst asserted during RECV -> on the same cycle busy=0, req_valid=0 and err_count=0; the next request follows POLL_CYCLES after rst is released.

Source files
------------

// File: rtl/ft6206_poll_controller.sv
// ---------------------------------------------------------------------------
// ft6206_poll_controller
//
// Periodically reads the FT6206 touch controller through an external I2C
// register-read engine. Every POLL_CYCLES clocks (while ena=1) it requests
// five bytes starting at register 0x02 (TD_STATUS, P1_XH, P1_XL, P1_YH,
// P1_YL), then publishes a clamped touch sample or counts an error.
//
// Ports:
//   clk, rst         system clock, asynchronous active-high reset
//   ena              polling enable (sampled only while idle)
//   req_valid/ready  request handshake to the I2C engine
//   req_addr/reg/len device address, start register, byte count
//   rd_valid/rd_data read byte stream from the engine
//   done, nack       transaction completion / abort pulses
//   touch_valid      one-cycle pulse while a new sample is presented
//   touch_active     at least one touch point present
//   touch_x/touch_y  clamped coordinates (0..239 / 0..319)
//   err_count        saturating count of failed transactions
//   busy             high whenever not idle
// ---------------------------------------------------------------------------
module ft6206_poll_controller #(
  parameter int         CLK_HZ         = 12_000_000,
  parameter int         POLL_HZ        = 100,
  parameter int         TIMEOUT_CYCLES = 4096,
  parameter logic [6:0] I2C_ADDR       = 7'h38
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  output logic       req_valid,
  input  logic       req_ready,
  output logic [6:0] req_addr,
  output logic [7:0] req_reg,
  output logic [2:0] req_len,
  input  logic       rd_valid,
  input  logic [7:0] rd_data,
  input  logic       done,
  input  logic       nack,
  output logic       touch_valid,
  output logic       touch_active,
  output logic [8:0] touch_x,
  output logic [8:0] touch_y,
  output logic [7:0] err_count,
  output logic       busy
);

  localparam int POLL_CYCLES = CLK_HZ / POLL_HZ;
  localparam int PT_W        = $clog2(POLL_CYCLES + 1);
  localparam int TO_W        = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [PT_W-1:0] POLL_RELOAD = PT_W'(POLL_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_LAST     = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_WAIT,
    S_REQ,
    S_RECV,
    S_UPDATE,
    S_ERR
  } state_t;

  state_t          state_q, state_d;
  logic [PT_W-1:0] timer_q, timer_d;
  logic [2:0]      idx_q, idx_d;
  logic [TO_W-1:0] to_q, to_d;
  logic [7:0]      bytes_q [5];
  logic [7:0]      bytes_d [5];
  logic            touch_valid_q, touch_valid_d;
  logic            touch_active_q, touch_active_d;
  logic [8:0]      touch_x_q, touch_x_d;
  logic [8:0]      touch_y_q, touch_y_d;
  logic [7:0]      err_count_q, err_count_d;

  logic [11:0]     raw_x, raw_y;
  logic [3:0]      td_status;

  function automatic logic [8:0] clamp_coord(input logic [11:0] v,
                                             input logic [11:0] lim);
    return (v > lim) ? lim[8:0] : v[8:0];
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Sample fields come from the next-cycle byte array so that a final byte
  // arriving together with done is already included.
  always_comb begin
    raw_x     = {bytes_d[1][3:0], bytes_d[2]};
    raw_y     = {bytes_d[3][3:0], bytes_d[4]};
    td_status = bytes_d[0][3:0];
  end

  always_comb begin
    state_d        = state_q;
    timer_d        = timer_q;
    idx_d          = idx_q;
    to_d           = to_q;
    bytes_d        = bytes_q;
    touch_valid_d  = 1'b0;
    touch_active_d = touch_active_q;
    touch_x_d      = touch_x_q;
    touch_y_d      = touch_y_q;
    err_count_d    = err_count_q;

    // Outside WAIT the poll timer free-runs down to 0 and parks there, so
    // the poll period does not stretch by the transaction length.
    if (state_q != S_WAIT && timer_q != '0) begin
      timer_d = timer_q - 1'b1;
    end

    case (state_q)
      S_WAIT: begin
        if (ena) begin
          if (timer_q == '0) begin
            state_d = S_REQ;
            timer_d = POLL_RELOAD;
          end else begin
            timer_d = timer_q - 1'b1;
          end
        end
      end

      S_REQ: begin
        if (req_ready) begin
          state_d = S_RECV;
          idx_d   = 3'd0;
          to_d    = '0;
        end
      end

      S_RECV: begin
        to_d = to_q + 1'b1;
        if (rd_valid) begin
          if (idx_q < 3'd5) begin
            bytes_d[idx_q] = rd_data;
          end
          if (idx_q != 3'd7) begin
            idx_d = idx_q + 3'd1;
          end
        end

        if (nack) begin
          state_d     = S_ERR;
          err_count_d = sat_inc8(err_count_q);
        end else if (done) begin
          if (idx_d == 3'd5) begin
            state_d        = S_UPDATE;
            touch_valid_d  = 1'b1;
            touch_active_d = (td_status != 4'd0) && (td_status <= 4'd2);
            if ((td_status != 4'd0) && (td_status <= 4'd2)) begin
              touch_x_d = clamp_coord(raw_x, 12'd239);
              touch_y_d = clamp_coord(raw_y, 12'd319);
            end
          end else begin
            state_d     = S_ERR;
            err_count_d = sat_inc8(err_count_q);
          end
        end else if (to_q == TO_LAST) begin
          state_d     = S_ERR;
          err_count_d = sat_inc8(err_count_q);
        end
      end

      S_UPDATE: state_d = S_WAIT;
      S_ERR:    state_d = S_WAIT;
      default:  state_d = S_WAIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_WAIT;
      timer_q        <= POLL_RELOAD;
      idx_q          <= 3'd0;
      to_q           <= '0;
      touch_valid_q  <= 1'b0;
      touch_active_q <= 1'b0;
      touch_x_q      <= 9'd0;
      touch_y_q      <= 9'd0;
      err_count_q    <= 8'd0;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      idx_q          <= idx_d;
      to_q           <= to_d;
      touch_valid_q  <= touch_valid_d;
      touch_active_q <= touch_active_d;
      touch_x_q      <= touch_x_d;
      touch_y_q      <= touch_y_d;
      err_count_q    <= err_count_d;
    end
  end

  // Raw byte buffer is pure data and is always rewritten before use.
  always_ff @(posedge clk) begin
    bytes_q <= bytes_d;
  end

  assign req_valid    = (state_q == S_REQ);
  assign req_addr     = I2C_ADDR;
  assign req_reg      = (state_q == S_REQ) ? 8'h02 : 8'h00;
  assign req_len      = (state_q == S_REQ) ? 3'd5 : 3'd0;
  assign busy         = (state_q != S_WAIT);
  assign touch_valid  = touch_valid_q;
  assign touch_active = touch_active_q;
  assign touch_x      = touch_x_q;
  assign touch_y      = touch_y_q;
  assign err_count    = err_count_q;

endmodule

// File: tb/tb_ft6206_poll_controller.sv
// ---------------------------------------------------------------------------
// tb_ft6206_poll_controller
//
// Directed bench for ft6206_poll_controller. Main instance: POLL_CYCLES=1000,
// TIMEOUT_CYCLES=400. A second instance with a 20-cycle poll period is fed
// nack on every request to exercise error-counter saturation.
// ---------------------------------------------------------------------------
module tb_ft6206_poll_controller;

  localparam int N_POLL = 1000;
  localparam int N_TO   = 400;

  logic       clk = 1'b0;
  logic       rst, ena, req_ready, rd_valid, done, nack;
  logic [7:0] rd_data;
  logic       req_valid, touch_valid, touch_active, busy;
  logic [6:0] req_addr;
  logic [7:0] req_reg, err_count;
  logic [2:0] req_len;
  logic [8:0] touch_x, touch_y;

  logic       f_rst, f_req_ready, f_rd_valid, f_done, f_nack;
  logic [7:0] f_rd_data;
  logic       f_req_valid, f_touch_valid, f_touch_active, f_busy;
  logic [6:0] f_req_addr;
  logic [7:0] f_req_reg, f_err_count;
  logic [2:0] f_req_len;
  logic [8:0] f_touch_x, f_touch_y;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  int f_nacks = 0;
  logic f_tv_seen = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ft6206_poll_controller #(
    .CLK_HZ(1_000_000), .POLL_HZ(1000), .TIMEOUT_CYCLES(N_TO), .I2C_ADDR(7'h38)
  ) u_dut (
    .clk(clk), .rst(rst), .ena(ena),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_reg(req_reg), .req_len(req_len),
    .rd_valid(rd_valid), .rd_data(rd_data), .done(done), .nack(nack),
    .touch_valid(touch_valid), .touch_active(touch_active),
    .touch_x(touch_x), .touch_y(touch_y), .err_count(err_count), .busy(busy)
  );

  ft6206_poll_controller #(
    .CLK_HZ(1_000_000), .POLL_HZ(50_000), .TIMEOUT_CYCLES(64), .I2C_ADDR(7'h38)
  ) u_fast (
    .clk(clk), .rst(f_rst), .ena(1'b1),
    .req_valid(f_req_valid), .req_ready(f_req_ready), .req_addr(f_req_addr),
    .req_reg(f_req_reg), .req_len(f_req_len),
    .rd_valid(f_rd_valid), .rd_data(f_rd_data), .done(f_done), .nack(f_nack),
    .touch_valid(f_touch_valid), .touch_active(f_touch_active),
    .touch_x(f_touch_x), .touch_y(f_touch_y), .err_count(f_err_count),
    .busy(f_busy)
  );

  task automatic chk(input string tag, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  // Waits (bounded) for req_valid at a falling edge; returns its cycle stamp.
  task automatic wait_req(input string tag, output int t);
    t = -1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (req_valid) begin
        t = cyc;
        break;
      end
    end
    chk(tag, req_valid, 1);
  endtask

  // Engine model. mode: 0 done after bytes, 1 done with last byte,
  // 2 nack after bytes, 3 nack+done together, 4 accept then go silent.
  // Returns on the falling edge after the terminating edge.
  task automatic serve(input logic [7:0] b0, b1, b2, b3, b4,
                       input int nb, input int mode);
    logic [7:0] bb [5];
    bb[0] = b0; bb[1] = b1; bb[2] = b2; bb[3] = b3; bb[4] = b4;
    req_ready = 1'b1;
    @(negedge clk);
    req_ready = 1'b0;
    for (int i = 0; i < nb; i++) begin
      if (mode == 1 && i == nb - 1) done = 1'b1;
      rd_valid = 1'b1;
      rd_data  = bb[i];
      @(negedge clk);
    end
    rd_valid = 1'b0;
    case (mode)
      0: done = 1'b1;
      2: nack = 1'b1;
      3: begin done = 1'b1; nack = 1'b1; end
      default: ;
    endcase
    if (mode == 0 || mode == 2 || mode == 3) @(negedge clk);
    done = 1'b0;
    nack = 1'b0;
  endtask

  // Fast instance: nack every request.
  initial begin
    f_rst = 1'b1; f_req_ready = 1'b0; f_rd_valid = 1'b0;
    f_rd_data = 8'h00; f_done = 1'b0; f_nack = 1'b0;
    repeat (2) @(negedge clk);
    f_rst = 1'b0;
    forever begin
      @(negedge clk);
      if (f_touch_valid) f_tv_seen = 1'b1;
      if (f_req_valid) begin
        f_req_ready = 1'b1;
        @(negedge clk);
        f_req_ready = 1'b0;
        f_nack = 1'b1;
        f_nacks++;
        @(negedge clk);
        f_nack = 1'b0;
      end
    end
  end

  initial begin
    int t0, t1, ca, e0;
    logic seen;

    rst = 1'b1; ena = 1'b1; req_ready = 1'b0; rd_valid = 1'b0;
    rd_data = 8'h00; done = 1'b0; nack = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req_valid", req_valid, 0);
    chk("rst_touch_valid", touch_valid, 0);
    chk("rst_touch_active", touch_active, 0);
    chk("rst_touch_x", touch_x, 0);
    chk("rst_touch_y", touch_y, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_busy", busy, 0);

    // First poll after reset release, basic sample
    rst = 1'b0;
    t0 = cyc;
    wait_req("req1_seen", t1);
    chk("req1_latency", t1 - t0, N_POLL);
    chk("req_addr", req_addr, 7'h38);
    chk("req_reg", req_reg, 8'h02);
    chk("req_len", req_len, 3'd5);
    serve(8'h01, 8'h00, 8'h64, 8'h01, 8'h2C, 5, 0);
    chk("s1_touch_valid", touch_valid, 1);
    chk("s1_touch_active", touch_active, 1);
    chk("s1_touch_x", touch_x, 100);
    chk("s1_touch_y", touch_y, 300);
    @(negedge clk);
    chk("s1_valid_pulse_end", touch_valid, 0);
    chk("s1_busy_idle", busy, 0);

    // Clamping, last byte arrives together with done
    t0 = t1;
    wait_req("req2_seen", t1);
    chk("req2_period", t1 - t0, N_POLL);
    serve(8'h02, 8'h0F, 8'hFF, 8'h0F, 8'hFF, 5, 1);
    chk("s2_touch_valid", touch_valid, 1);
    chk("s2_touch_active", touch_active, 1);
    chk("s2_touch_x", touch_x, 239);
    chk("s2_touch_y", touch_y, 319);

    // No touch: coordinates hold
    wait_req("req3_seen", t1);
    serve(8'h00, 8'h01, 8'h02, 8'h00, 8'h03, 5, 0);
    chk("s3_touch_valid", touch_valid, 1);
    chk("s3_touch_active", touch_active, 0);
    chk("s3_touch_x_hold", touch_x, 239);
    chk("s3_touch_y_hold", touch_y, 319);

    // TD_STATUS=3 is treated as no touch
    wait_req("req4_seen", t1);
    serve(8'h03, 8'h00, 8'h10, 8'h00, 8'h20, 5, 0);
    chk("s4_touch_active", touch_active, 0);
    chk("s4_touch_x_hold", touch_x, 239);

    // nack after 2 bytes
    wait_req("req5_seen", t1);
    serve(8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 2, 2);
    chk("nack_no_valid", touch_valid, 0);
    chk("nack_err_count", err_count, 1);
    chk("nack_busy_err", busy, 1);
    @(negedge clk);
    chk("nack_no_valid_after", touch_valid, 0);

    // done with only 3 bytes
    wait_req("req6_seen", t1);
    serve(8'h01, 8'h00, 8'h05, 8'h00, 8'h00, 3, 0);
    chk("short_no_valid", touch_valid, 0);
    chk("short_err_count", err_count, 2);

    // nack and done together after 5 bytes: nack wins
    wait_req("req7_seen", t1);
    serve(8'h01, 8'h00, 8'h05, 8'h00, 8'h06, 5, 3);
    chk("nackdone_no_valid", touch_valid, 0);
    chk("nackdone_err_count", err_count, 3);
    chk("nackdone_x_hold", touch_x, 239);

    // Timeout: silent engine
    wait_req("req8_seen", t1);
    serve(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 4);
    ca = cyc;
    e0 = err_count;
    for (int i = 0; i < 2 * N_TO; i++) begin
      if (err_count != 8'(e0)) break;
      @(negedge clk);
    end
    chk("timeout_latency", cyc - ca, N_TO);
    chk("timeout_err_count", err_count, 4);
    chk("timeout_no_valid", touch_valid, 0);
    t0 = t1;
    wait_req("req9_seen", t1);
    chk("timeout_resume_period", t1 - t0, N_POLL);

    // Request held while engine not ready
    for (int i = 0; i < 50; i++) begin
      chk("hold_req_valid", req_valid, 1);
      chk("hold_req_reg", req_reg, 8'h02);
      chk("hold_req_len", req_len, 3'd5);
      @(negedge clk);
    end
    serve(8'h01, 8'h00, 8'h0A, 8'h00, 8'h14, 5, 0);
    chk("late_touch_x", touch_x, 10);
    chk("late_touch_y", touch_y, 20);
    t0 = t1;
    wait_req("req10_seen", t1);
    chk("late_period", t1 - t0, N_POLL);

    // Reset during RECV
    req_ready = 1'b1;
    @(negedge clk);
    req_ready = 1'b0;
    rd_valid = 1'b1; rd_data = 8'h01;
    @(negedge clk);
    rd_data = 8'h00;
    @(negedge clk);
    rd_valid = 1'b0;
    chk("recv_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_req_valid", req_valid, 0);
    chk("midrst_err_count", err_count, 0);
    chk("midrst_touch_x", touch_x, 0);
    @(negedge clk);
    rst = 1'b0;
    t0 = cyc;
    wait_req("req11_seen", t1);
    chk("midrst_req_latency", t1 - t0, N_POLL);
    serve(8'h02, 8'h00, 8'h05, 8'h00, 8'h07, 5, 0);
    chk("s11_touch_x", touch_x, 5);
    chk("s11_touch_y", touch_y, 7);

    // ena low at reset release
    @(negedge clk);
    rst = 1'b1;
    ena = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (req_valid) seen = 1'b1;
    end
    chk("ena0_no_req", seen, 0);
    ena = 1'b1;
    t0 = cyc;
    wait_req("req12_seen", t1);
    chk("ena1_req_latency", t1 - t0, N_POLL);
    serve(8'h01, 8'h00, 8'hC8, 8'h00, 8'hC8, 5, 0);
    chk("s12_touch_x", touch_x, 200);
    chk("s12_touch_y", touch_y, 200);

    // Saturation on the fast instance
    chk("fast_enough_nacks", (f_nacks >= 300) ? 1 : 0, 1);
    chk("fast_err_saturated", f_err_count, 255);
    chk("fast_no_touch_valid", f_tv_seen, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
